issue_scoreboard: RTL

In-order issue controller for the core. It sits between Decode and the two execution resources: the single-cycle ALU and the multi-cycle Load_Store unit. It holds decoded instructions until RAW and WAW hazards and unit and writeback-port conflicts clear. It then issues each instruction to exactly one unit and arbitrates the single ARF write port between the units.

---
 rtl/core_pkg.sv | 9 +
 rtl/lsu_tracker.sv | 51 +++++
 rtl/issue_scoreboard.sv | 95 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core constants: register file geometry, writeback-select encoding
// and the default load/store latency.
package core_pkg;
  localparam int NREG = 32;
  localparam int REG_W = 5;
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_LSU = 1'b1;
  localparam int LSU_LAT_DEFAULT = 3;
endpackage

// File: rtl/lsu_tracker.sv
// Occupancy and completion tracking for the multi-cycle load/store unit.
// Reports when the unit is idle and when its writeback lands next cycle.
module lsu_tracker
  import core_pkg::*;
#(
  parameter int LSU_LAT = LSU_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [REG_W-1:0] rd,
  input  logic             w,
  output logic             idle,
  output logic             done_next,
  output logic             pend_w,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd
);
  // The issue cycle counts as the first cycle of latency, so the counter is
  // loaded one short; writeback then lands exactly LSU_LAT cycles after issue.
  localparam logic [3:0] LOAD = 4'(LSU_LAT - 1);

  logic [3:0]       cnt;
  logic [REG_W-1:0] lsu_rd;
  logic             lsu_w;
  logic             done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      lsu_rd <= '0;
      lsu_w  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_next;
      if (issue) begin
        cnt    <= LOAD;
        lsu_rd <= rd;
        lsu_w  <= w;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign idle      = (cnt == 4'd0);
  assign done_next = (cnt == 4'd1);
  assign pend_w    = lsu_w;
  assign wb_valid  = done_q & lsu_w;
  assign wb_rd     = wb_valid ? lsu_rd : '0;
endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue controller: register scoreboard, ALU/LSU routing and
// arbitration of the single architectural register write port.
module issue_scoreboard
  import core_pkg::*;
#(
  parameter int LSU_LAT = LSU_LAT_DEFAULT,
  parameter int NREG    = core_pkg::NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_uses_rs2,
  input  logic             dec_regwrite,
  input  logic             dec_is_mem,
  output logic             alu_issue,
  output logic             lsu_issue,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_sel,
  output logic [NREG-1:0]  busy_vec,
  output logic [15:0]      stall_cnt
);
  logic [NREG-1:0]  busy, busy_next, set_mask, clr_mask;
  logic             started;
  logic             alu_v, alu_w, alu_wb;
  logic [REG_W-1:0] alu_rd;
  logic             lsu_idle, lsu_done_next, lsu_pend_w, lsu_wb_valid;
  logic [REG_W-1:0] lsu_wb_rd;
  logic             raw_ok, waw_ok, unit_ok;

  lsu_tracker #(.LSU_LAT(LSU_LAT)) u_lsu (
    .clk       (clk),
    .rst       (rst),
    .issue     (lsu_issue),
    .rd        (dec_rd),
    .w         (dec_regwrite),
    .idle      (lsu_idle),
    .done_next (lsu_done_next),
    .pend_w    (lsu_pend_w),
    .wb_valid  (lsu_wb_valid),
    .wb_rd     (lsu_wb_rd)
  );

  // Only registered busy bits are consulted; a bit clearing this cycle still blocks.
  assign raw_ok  = ~busy[dec_rs1] & ~(dec_uses_rs2 & busy[dec_rs2]);
  assign waw_ok  = ~(dec_regwrite & busy[dec_rd]);
  assign unit_ok = dec_is_mem ? lsu_idle
                              : ~(dec_regwrite & lsu_done_next & lsu_pend_w);

  assign dec_ready = started & dec_valid & raw_ok & waw_ok & unit_ok;
  assign alu_issue = dec_ready & ~dec_is_mem;
  assign lsu_issue = dec_ready & dec_is_mem;

  // The LSU wins the write port; the issue rule keeps the ALU off its cycle.
  assign alu_wb   = alu_v & alu_w & (alu_rd != '0);
  assign wb_valid = alu_wb | lsu_wb_valid;
  assign wb_sel   = lsu_wb_valid ? WB_SEL_LSU : WB_SEL_ALU;
  assign wb_rd    = lsu_wb_valid ? lsu_wb_rd : (alu_wb ? alu_rd : '0);
  assign busy_vec = busy;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wb_valid) clr_mask[wb_rd] = 1'b1;
    if (dec_ready && dec_regwrite && dec_rd != '0) set_mask[dec_rd] = 1'b1;
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      started   <= 1'b0;
      alu_v     <= 1'b0;
      alu_w     <= 1'b0;
      alu_rd    <= '0;
      stall_cnt <= '0;
    end else begin
      busy    <= busy_next;
      started <= 1'b1;
      alu_v   <= alu_issue;
      alu_w   <= alu_issue & dec_regwrite;
      alu_rd  <= alu_issue ? dec_rd : '0;
      if (dec_valid && !dec_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  a_no_set_clr_same_bit: assert property (@(posedge clk) disable iff (rst)
    ~|(set_mask & clr_mask));
endmodule
